// File: rtl/ad9833_pkg.sv
// Shared constants for the multi-chip AD9833 Avalon slave: register map,
// STATUS bit positions, TXDATA channel field and serializer states.
package ad9833_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    localparam int ST_BUSY      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_FULL      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_BAD_CH    = 4;
    localparam int ST_IRQ       = 5;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_LAST_LSB  = 16;

    localparam int CH_LSB = 16;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/ad9833_multi_avalon_if.sv
// Avalon-MM slave bus bundle for the AD9833 controller (no waitrequest,
// registered readdata).
interface ad9833_multi_avalon_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write, read, byteenable, writedata,
                    input readdata);
    modport slave  (input address, chipselect, write, read, byteenable, writedata,
                    output readdata);
endinterface

// File: rtl/ad9833_shifter.sv
// Frame serializer: pops one {channel, word} entry and shifts it MSB first on
// the shared SCLK/SDATA bus under that channel's FSYNC.
//
// state | meaning
// IDLE  | bus idle, pops an entry when one is available
// SETUP | fsync low, sclk high, sdata = MSB, for CLK_DIV cycles
// SHIFT | per bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles
// HOLD  | fsync released, sdata = 0, for CLK_DIV cycles
module ad9833_shifter import ad9833_pkg::*; #(
    parameter int NUM_CH  = 4,
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pop_valid,
    output logic              pop_ready,
    input  logic [WORD_W-1:0] pop_word,
    input  logic [CH_W-1:0]   pop_ch,
    output logic              busy,
    output logic              sclk,
    output logic              sdata,
    output logic [NUM_CH-1:0] fsync_n,
    output logic [WORD_W-1:0] last_word
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SETUP = SETUP;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_HOLD  = HOLD;

    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WORD_W - 1);

    logic [1:0]        state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_q;

    assign pop_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_q    <= '0;
            sclk      <= 1'b1;
            sdata     <= 1'b0;
            fsync_n   <= '1;
            last_word <= '0;
        end else begin
            case (state)
                S_IDLE: if (pop_valid) begin
                    state   <= S_SETUP;
                    div_cnt <= DIV_LOAD;
                    shreg   <= pop_word;
                    word_q  <= pop_word;
                    fsync_n <= ~(NUM_CH'(1) << pop_ch);
                    sclk    <= 1'b1;
                    sdata   <= pop_word[WORD_W-1];
                end
                S_SETUP: if (div_cnt == '0) begin
                    state   <= S_SHIFT;
                    sclk    <= 1'b0;
                    div_cnt <= DIV_LOAD;
                    bit_cnt <= BIT_LOAD;
                end else begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end
                S_SHIFT: if (div_cnt != '0) begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end else if (!sclk) begin
                    // chip has sampled on the falling edge; present the next bit with the rise
                    sclk    <= 1'b1;
                    div_cnt <= DIV_LOAD;
                    sdata   <= shreg[WORD_W-2];
                    shreg   <= {shreg[WORD_W-2:0], 1'b0};
                end else if (bit_cnt == '0) begin
                    state     <= S_HOLD;
                    div_cnt   <= DIV_LOAD;
                    fsync_n   <= '1;
                    sdata     <= 1'b0;
                    last_word <= word_q;
                end else begin
                    sclk    <= 1'b0;
                    div_cnt <= DIV_LOAD;
                    bit_cnt <= bit_cnt - BIT_W'(1);
                end
                S_HOLD: if (div_cnt == '0) begin
                    state <= S_IDLE;
                end else begin
                    div_cnt <= div_cnt - DIV_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ad9833_multi_avalon.sv
// Avalon-MM front end for NUM_CH AD9833 chips: TXDATA writes queue frames in a
// FIFO drained by ad9833_shifter. Optional irq output via AD9833_IRQ_EN.
module ad9833_multi_avalon import ad9833_pkg::*; #(
    parameter int NUM_CH     = 4,
    parameter int WORD_W     = 16,
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        resetn,
    ad9833_multi_avalon_if.slave        avs,
    output logic                        sclk,
    output logic                        sdata,
    output logic [NUM_CH-1:0]           fsync_n
`ifdef AD9833_IRQ_EN
    , output logic                      irq
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int ENT_W = WORD_W + CH_W;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic [CH_W-1:0]   wr_ch;
    logic              tx_wr, st_wr, rd_req, ch_ok;
    logic              fifo_empty, fifo_full, push, pop, pop_ready, busy;
    logic              ovf, bad_ch, irq_pend;
    logic [WORD_W-1:0] last_word;
    logic [31:0]       status;

    assign wr_ch  = avs.writedata[CH_LSB +: CH_W];
    assign ch_ok  = int'(wr_ch) < NUM_CH;
    assign tx_wr  = avs.chipselect && avs.write && (avs.address == ADDR_TXDATA)
                    && (avs.byteenable[1:0] == 2'b11);
    assign st_wr  = avs.chipselect && avs.write && (avs.address == ADDR_STATUS);
    assign rd_req = avs.chipselect && avs.read;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && pop_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push       = tx_wr && ch_ok && (!fifo_full || pop);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {wr_ch, avs.writedata[WORD_W-1:0]};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            bad_ch <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (tx_wr && ch_ok && fifo_full && !pop) ovf <= 1'b1;
            else if (st_wr && avs.writedata[ST_OVF]) ovf <= 1'b0;
            if (tx_wr && !ch_ok) bad_ch <= 1'b1;
            else if (st_wr && avs.writedata[ST_BAD_CH]) bad_ch <= 1'b0;
        end
    end

`ifdef AD9833_IRQ_EN
    logic busy_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_q   <= 1'b0;
            irq_pend <= 1'b0;
        end else begin
            busy_q <= busy;
            if (busy_q && !busy && fifo_empty) irq_pend <= 1'b1;
            else if (st_wr && avs.writedata[ST_IRQ]) irq_pend <= 1'b0;
        end
    end

    assign irq = irq_pend;
`else
    assign irq_pend = 1'b0;
`endif

    always_comb begin
        status                           = '0;
        status[ST_BUSY]                  = busy;
        status[ST_EMPTY]                 = fifo_empty;
        status[ST_FULL]                  = fifo_full;
        status[ST_OVF]                   = ovf;
        status[ST_BAD_CH]                = bad_ch;
        status[ST_IRQ]                   = irq_pend;
        status[ST_COUNT_LSB +: 8]        = 8'(count);
        status[ST_LAST_LSB +: WORD_W]    = last_word;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                                     avs.readdata <= '0;
        else if (rd_req && avs.address == ADDR_STATUS)   avs.readdata <= status;
        else                                             avs.readdata <= '0;
    end

    ad9833_shifter #(
        .NUM_CH  (NUM_CH),
        .WORD_W  (WORD_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock     (clock),
        .resetn    (resetn),
        .pop_valid (!fifo_empty),
        .pop_ready (pop_ready),
        .pop_word  (head[WORD_W-1:0]),
        .pop_ch    (head[ENT_W-1 -: CH_W]),
        .busy      (busy),
        .sclk      (sclk),
        .sdata     (sdata),
        .fsync_n   (fsync_n),
        .last_word (last_word)
    );

endmodule

// File: tb/tb_ad9833_multi_avalon.sv
// Directed bench for ad9833_multi_avalon (NUM_CH=4, WORD_W=16, CLK_DIV=2,
// FIFO_DEPTH=8); expected values are hand-computed constants.
module tb_ad9833_multi_avalon;

    localparam int NUM_CH     = 4;
    localparam int WORD_W     = 16;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 8;
    localparam int LOW_CYC    = (2 * WORD_W + 1) * CLK_DIV;   // SETUP + SHIFT = 66
    localparam int GAP_CYC    = CLK_DIV + 1;                  // HOLD + one IDLE

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              sclk, sdata;
    logic [NUM_CH-1:0] fsync_n;
`ifdef AD9833_IRQ_EN
    logic              irq;
`endif
    int chk_cnt  = 0;
    int pass_cnt = 0;

    ad9833_multi_avalon_if avs();

    ad9833_multi_avalon #(
        .NUM_CH     (NUM_CH),
        .WORD_W     (WORD_W),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .avs     (avs),
        .sclk    (sclk),
        .sdata   (sdata),
        .fsync_n (fsync_n)
`ifdef AD9833_IRQ_EN
        , .irq   (irq)
`endif
    );

    always #5 clock = ~clock;

    // all bus tasks start and end 1 ns after a rising edge
    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        avs.address = a; avs.writedata = d; avs.byteenable = be;
        avs.chipselect = 1'b1; avs.write = 1'b1;
        step();
        avs.chipselect = 1'b0; avs.write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs.address = a; avs.chipselect = 1'b1; avs.read = 1'b1;
        step();
        avs.chipselect = 1'b0; avs.read = 1'b0;
        d = avs.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        avs.address = 2'd0; avs.chipselect = 1'b0; avs.write = 1'b0; avs.read = 1'b0;
        avs.byteenable = 4'h0; avs.writedata = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_cnt++; if (sclk !== 1'b1) $display("FAIL reset_sclk got %b want 1", sclk); else pass_cnt++;
        chk_cnt++; if (sdata !== 1'b0) $display("FAIL reset_sdata got %b want 0", sdata); else pass_cnt++;
        chk_cnt++; if (fsync_n !== 4'hF) $display("FAIL reset_fsync got %h want f", fsync_n); else pass_cnt++;
        chk_cnt++; if (avs.readdata !== 32'h0) $display("FAIL reset_readdata got %h want 0", avs.readdata); else pass_cnt++;
        resetn = 1'b1;
        step();
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h0000_0002) $display("FAIL reset_status got %h want 00000002", d); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        logic [15:0] rx = '0;
        logic [31:0] d;
        int nbits = 0, low = 0;
        logic prev = 1'b1;
        bit done = 0;
        bus_write(2'd0, 32'h0002_2100, 4'hF);
        for (int c = 0; c < 300 && !done; c++) begin
            if (fsync_n == 4'b1011) begin
                low++;
                if (prev && !sclk) begin rx = {rx[14:0], sdata}; nbits++; end
            end else if (low > 0) done = 1;
            prev = sclk;
            if (!done) step();
        end
        chk_cnt++; if (!done) $display("FAIL single_timeout got low=%0d want frame end", low); else pass_cnt++;
        chk_cnt++; if (low != LOW_CYC) $display("FAIL single_fsync_len got %0d want %0d", low, LOW_CYC); else pass_cnt++;
        chk_cnt++; if (nbits != 16 || rx !== 16'h2100) $display("FAIL single_bits got %h/%0d want 2100/16", rx, nbits); else pass_cnt++;
        // now 1 ns after the first HOLD edge; busy must drop exactly at cycle 68
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h2100_0003) $display("FAIL single_hold1 got %h want 21000003", d); else pass_cnt++;
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h2100_0003) $display("FAIL single_hold2 got %h want 21000003", d); else pass_cnt++;
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h2100_0002) $display("FAIL single_idle got %h want 21000002", d); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] d = '0;
        bit ok = 0;
        for (int i = 0; i < 10; i++) bus_write(2'd0, 32'h0001_1000 + 32'(i), 4'hF);
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h2100_080D) $display("FAIL ovf_status got %h want 2100080d", d); else pass_cnt++;
        bus_write(2'd1, 32'h0000_0008, 4'hF);
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h2100_0805) $display("FAIL ovf_clear got %h want 21000805", d); else pass_cnt++;
        for (int c = 0; c < 3000 && !ok; c++) begin
            bus_read(2'd1, d);
            if (d[0] == 1'b0 && d[1] == 1'b1) ok = 1;
        end
        chk_cnt++; if (!ok) $display("FAIL ovf_drain_timeout got %h want idle+empty", d); else pass_cnt++;
        chk_cnt++; if (d !== 32'h1008_0002) $display("FAIL ovf_drained got %h want 10080002", d); else pass_cnt++;
    endtask

    task automatic test_bad_ch_byteenable();
        logic [31:0] d;
        bit bad = 0;
        bus_write(2'd0, 32'h0005_1234, 4'hF);
        for (int c = 0; c < 20; c++) begin if (fsync_n !== 4'hF) bad = 1; step(); end
        chk_cnt++; if (bad) $display("FAIL badch_frame got frame want none"); else pass_cnt++;
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h1008_0012) $display("FAIL badch_status got %h want 10080012", d); else pass_cnt++;
        bus_write(2'd1, 32'h0000_0010, 4'hF);
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h1008_0002) $display("FAIL badch_clear got %h want 10080002", d); else pass_cnt++;
        bus_write(2'd0, 32'h0000_4321, 4'b0001);
        bad = 0;
        for (int c = 0; c < 20; c++) begin if (fsync_n !== 4'hF) bad = 1; step(); end
        chk_cnt++; if (bad) $display("FAIL be_frame got frame want none"); else pass_cnt++;
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h1008_0002) $display("FAIL be_status got %h want 10080002", d); else pass_cnt++;
        bus_read(2'd0, d);
        chk_cnt++; if (d !== 32'h0) $display("FAIL rd_txdata got %h want 0", d); else pass_cnt++;
        bus_read(2'd2, d);
        chk_cnt++; if (d !== 32'h0) $display("FAIL rd_addr2 got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx1 = '0, rx2 = '0;
        int low1 = 0, low2 = 0, gap = 0, bad = 0, phase = 0;
        logic prev = 1'b1;
        bus_write(2'd0, 32'h0000_AAAA, 4'hF);
        bus_write(2'd0, 32'h0003_5555, 4'hF);
        for (int c = 0; c < 400 && phase != 4; c++) begin
            case (fsync_n)
                4'b1110: if (phase <= 1) begin
                    phase = 1; low1++;
                    if (prev && !sclk) rx1 = {rx1[14:0], sdata};
                end else bad++;
                4'b0111: if (phase == 2 || phase == 3) begin
                    phase = 3; low2++;
                    if (prev && !sclk) rx2 = {rx2[14:0], sdata};
                end else bad++;
                4'b1111: begin
                    if (phase == 1) phase = 2;
                    if (phase == 2) gap++;
                    if (phase == 3) phase = 4;
                end
                default: bad++;
            endcase
            prev = sclk;
            if (phase != 4) step();
        end
        chk_cnt++; if (phase != 4) $display("FAIL b2b_timeout got phase %0d want 4", phase); else pass_cnt++;
        chk_cnt++; if (bad != 0) $display("FAIL b2b_overlap got %0d bad cycles want 0", bad); else pass_cnt++;
        chk_cnt++; if (low1 != LOW_CYC) $display("FAIL b2b_len0 got %0d want %0d", low1, LOW_CYC); else pass_cnt++;
        chk_cnt++; if (gap != GAP_CYC) $display("FAIL b2b_gap got %0d want %0d", gap, GAP_CYC); else pass_cnt++;
        chk_cnt++; if (low2 != LOW_CYC) $display("FAIL b2b_len3 got %0d want %0d", low2, LOW_CYC); else pass_cnt++;
        chk_cnt++; if (rx1 !== 16'hAAAA) $display("FAIL b2b_word0 got %h want aaaa", rx1); else pass_cnt++;
        chk_cnt++; if (rx2 !== 16'h5555) $display("FAIL b2b_word3 got %h want 5555", rx2); else pass_cnt++;
        repeat (10) step();
    endtask

    task automatic test_midframe_reset();
        logic [31:0] d;
        int falls = 0;
        logic prev = 1'b1;
        bit bad = 0;
        bus_write(2'd0, 32'h0001_FFFF, 4'hF);
        bus_write(2'd0, 32'h0002_0F0F, 4'hF);
        // 9th falling edge is bit 7
        for (int c = 0; c < 200 && falls < 9; c++) begin
            if (fsync_n == 4'b1101 && prev && !sclk) falls++;
            prev = sclk;
            if (falls < 9) step();
        end
        chk_cnt++; if (falls != 9) $display("FAIL mid_timeout got %0d falls want 9", falls); else pass_cnt++;
        resetn = 1'b0;
        #1;
        chk_cnt++; if (sclk !== 1'b1) $display("FAIL mid_sclk got %b want 1", sclk); else pass_cnt++;
        chk_cnt++; if (sdata !== 1'b0) $display("FAIL mid_sdata got %b want 0", sdata); else pass_cnt++;
        chk_cnt++; if (fsync_n !== 4'hF) $display("FAIL mid_fsync got %h want f", fsync_n); else pass_cnt++;
        step(); step();
        resetn = 1'b1;
        for (int c = 0; c < 150; c++) begin if (fsync_n !== 4'hF) bad = 1; step(); end
        chk_cnt++; if (bad) $display("FAIL mid_restart got frame want none"); else pass_cnt++;
        bus_read(2'd1, d);
        chk_cnt++; if (d !== 32'h0000_0002) $display("FAIL mid_status got %h want 00000002", d); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_bad_ch_byteenable();
        test_back_to_back();
        test_midframe_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
